// File: rtl/pio_cmd_pkg.sv
// pio_cmd_pkg: shared state encoding and status bit positions for the PIO command sequencer
package pio_cmd_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RUN = 2'd2, DONE = 2'd3} state_e;
  localparam int STATUS_BUSY    = 0;
  localparam int STATUS_DONE    = 1;
  localparam int STATUS_ERROR   = 2;
  localparam int STATUS_TIMEOUT = 3;
endpackage

// File: rtl/pio_sync_edge.sv
// pio_sync_edge: multi-flop synchroniser for an asynchronous level with rise/fall detection
module pio_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_async,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_async};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  assign q    = sync_q[SYNC_STAGES-1];
  assign rise = q & ~prev_q;
  assign fall = ~q & prev_q;
endmodule

// File: rtl/pio_cmd_sequencer.sv
// pio_cmd_sequencer: turns a software command level into a start/done handshake with a compute core
module pio_cmd_sequencer
  import pio_cmd_pkg::*;
#(
  parameter int          SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int          CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_level,
  input  logic             core_ready,
  input  logic             core_done,
  input  logic             core_error,
  output logic             core_start,
  output logic             core_abort,
  output logic [3:0]       status,
  output logic [CNT_W-1:0] run_cycles
);
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] run_cycles_q;
  logic [3:0]       status_q;
  logic             start_q;
  logic             abort_q;
  logic             cmd_sync;
  logic             rise;
  logic             fall;
  logic             to_hit;
  logic             fin;
  pio_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_async (cmd_level),
    .q       (cmd_sync),
    .rise    (rise),
    .fall    (fall)
  );
  assign to_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES));
  assign fin    = core_error | core_done | to_hit;
  // ISSUE is only entered with cmd_sync high, so a fall there is exactly a cancel
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      run_cycles_q <= '0;
      status_q     <= '0;
      start_q      <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      start_q <= 1'b0;
      abort_q <= 1'b0;
      case (state_q)
        IDLE:
          if (rise) begin
            state_q               <= ISSUE;
            status_q[STATUS_BUSY] <= 1'b1;
          end
        ISSUE:
          if (fall) begin
            state_q  <= IDLE;
            status_q <= '0;
          end else if (core_ready) begin
            state_q <= RUN;
            start_q <= 1'b1;
            cnt_q   <= CNT_W'(1);
          end
        RUN: begin
          cnt_q <= &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
          if (fin) begin
            state_q                  <= DONE;
            run_cycles_q             <= cnt_q;
            status_q[STATUS_BUSY]    <= 1'b0;
            status_q[STATUS_ERROR]   <= core_error;
            status_q[STATUS_DONE]    <= ~core_error;
            status_q[STATUS_TIMEOUT] <= ~core_error & ~core_done;
            abort_q                  <= ~core_error & ~core_done;
          end
        end
        DONE:
          if (!cmd_sync) begin
            state_q  <= IDLE;
            status_q <= '0;
          end
      endcase
    end
  assign core_start = start_q;
  assign core_abort = abort_q;
  assign status     = status_q;
  assign run_cycles = run_cycles_q;
endmodule

// File: tb/tb_pio_cmd_sequencer.sv
// tb_pio_cmd_sequencer: scoreboard bench for the PIO command sequencer handshake
module tb_pio_cmd_sequencer;
  localparam int TO = 50;
  typedef struct packed {logic [3:0] st; logic [31:0] rc;} exp_t;
  logic        clk = 1'b0;
  logic        reset_n, cmd_level, core_ready, core_done, core_error;
  logic        core_start, core_abort;
  logic [3:0]  status;
  logic [31:0] run_cycles;
  int          checks = 0, failures = 0, starts = 0, aborts = 0;
  int          s0, lat, at;
  logic        busy_prev = 1'b0;
  exp_t        sbq[$];
  exp_t        e;
  always #5 clk = ~clk;
  pio_cmd_sequencer #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TO), .CNT_W(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_level  (cmd_level),
    .core_ready (core_ready),
    .core_done  (core_done),
    .core_error (core_error),
    .core_start (core_start),
    .core_abort (core_abort),
    .status     (status),
    .run_cycles (run_cycles)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic wait_start(output int l);
    l = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (core_start) begin
        l = i;
        break;
      end
    end
  endtask
  task automatic expect_end(input logic [3:0] st, input int rc);
    sbq.push_back({st, 32'(rc)});
  endtask
  always @(negedge clk) begin
    if (core_start) starts++;
    if (core_abort) aborts++;
    if (busy_prev && !status[0] && (status[1] | status[2])) begin
      check("sb_pending", sbq.size() != 0, 1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        check("sb_status", status, e.st);
        check("sb_run_cycles", run_cycles, e.rc);
      end
    end
    busy_prev = status[0];
  end
  initial begin
    reset_n = 0; cmd_level = 0; core_ready = 0; core_done = 0; core_error = 0;
    #23;
    check("rst_status", status, 0);
    check("rst_start", core_start, 0);
    check("rst_abort", core_abort, 0);
    check("rst_run_cycles", run_cycles, 0);
    @(posedge clk); #1; reset_n = 1;
    tick(3);
    // 1: nominal run, done at count 10
    s0 = starts; core_ready = 1; cmd_level = 1;
    wait_start(lat);
    check("t1_latency", lat, 4);
    check("t1_busy", status, 4'b0001);
    expect_end(4'b0010, 10);
    tick(9); core_done = 1; tick(); core_done = 0;
    check("t1_status_done", status, 4'b0010);
    check("t1_run_cycles", run_cycles, 10);
    tick(5);
    check("t1_hold", status, 4'b0010);
    check("t1_starts", starts - s0, 1);
    cmd_level = 0; tick(3);
    check("t1_cleared", status, 4'b0000);
    check("t1_rc_persist", run_cycles, 10);
    // 2: core not ready for 20 cycles
    s0 = starts; core_ready = 0; cmd_level = 1;
    tick(20);
    check("t2_no_start", starts - s0, 0);
    check("t2_busy", status, 4'b0001);
    core_ready = 1;
    wait_start(lat);
    check("t2_latency", lat, 1);
    expect_end(4'b0010, 3);
    tick(2); core_done = 1; tick(); core_done = 0;
    check("t2_status", status, 4'b0010);
    tick(3);
    check("t2_single_start", starts - s0, 1);
    cmd_level = 0; tick(3);
    check("t2_cleared", status, 4'b0000);
    // 3: timeout
    cmd_level = 1;
    wait_start(lat);
    check("t3_latency", lat, 4);
    expect_end(4'b1010, TO);
    at = -1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (core_abort) begin
        at = i;
        break;
      end
    end
    check("t3_abort_at", at, TO);
    check("t3_status", status, 4'b1010);
    check("t3_run_cycles", run_cycles, TO);
    core_done = 1; tick(); core_done = 0;
    check("t3_abort_pulse", core_abort, 0);
    check("t3_done_ignored", status, 4'b1010);
    cmd_level = 0; tick(3);
    check("t3_cleared", status, 4'b0000);
    // 4: done and error together
    cmd_level = 1;
    wait_start(lat);
    expect_end(4'b0100, 5);
    tick(4); core_done = 1; core_error = 1; tick(); core_done = 0; core_error = 0;
    check("t4_status", status, 4'b0100);
    check("t4_run_cycles", run_cycles, 5);
    cmd_level = 0; tick(3);
    check("t4_cleared", status, 4'b0000);
    // 5: cancel while waiting for ready
    s0 = starts; core_ready = 0; cmd_level = 1;
    tick(4);
    check("t5_busy", status, 4'b0001);
    cmd_level = 0; tick(3);
    check("t5_idle", status, 4'b0000);
    core_ready = 1; tick(5);
    check("t5_no_start", starts - s0, 0);
    // 6: reset mid-run
    cmd_level = 1;
    wait_start(lat);
    tick(5);
    check("t6_busy", status, 4'b0001);
    #2; reset_n = 0; cmd_level = 0; #1;
    check("t6_rst_status", status, 0);
    check("t6_rst_run_cycles", run_cycles, 0);
    check("t6_rst_start", core_start, 0);
    tick(2);
    check("t6_rst_abort", core_abort, 0);
    reset_n = 1; tick(3);
    cmd_level = 1;
    wait_start(lat);
    check("t6_latency", lat, 4);
    expect_end(4'b0010, 7);
    tick(6); core_done = 1; tick(); core_done = 0;
    check("t6_status", status, 4'b0010);
    check("t6_run_cycles", run_cycles, 7);
    cmd_level = 0; tick(3);
    check("t6_cleared", status, 4'b0000);
    check("aborts_total", aborts, 1);
    check("sb_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
